cmp_bist: RTL and testbench
===========================

# cmp_bist

Built-in self-test sequencer for the 16-bit datapath magnitude comparator. It generates operand pairs and drives them into the comparator. It samples the comparator's greater-than output after a configurable latency, checks it against an internal expected-value model, and reports pass/fail through a start/busy/done handshake. It sits beside the comparator in the execute stage, and the processor's test controller or a bench triggers it.

## Interface
- `WIDTH`, 16: operand width in bits.
- `DUT_LAT`, 0: register stages inside the comparator under test; legal range 0..3.
- `clk`  in  1  single clock; every register updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a sweep; ignored while `busy`.
- `a_out`  out  WIDTH  operand A driven to the comparator.
- `b_out`  out  WIDTH  operand B driven to the comparator.
- `dut_gt`  in  1  comparator result; 1 means A > B.
- `busy`  out  1  high while a sweep is in progress.
- `done`  out  1  high from sweep end until the next `start` or reset.
- `pass`  out  1  valid while `done`; 1 means every vector matched.
- `fail_a`  out  WIDTH  A of the first mismatching vector; 0 if none.
- `fail_b`  out  WIDTH  B of the first mismatching vector; 0 if none.

## Operation
- **States:** IDLE, RUN, DONE.
- **Reset values:**
  - State is IDLE.
  - `a_out` = all ones and `b_out` = 0.
  - `busy`, `done`, `pass` are 0.
  - `fail_a` and `fail_b` are 0.
  - Wait counter is 0.
- **IDLE or DONE, `start`=1:**
  - Load `a_out` = all ones and `b_out` = 0.
  - Clear `done`, `pass`, `fail_a`, `fail_b` and the wait counter.
  - Go to RUN.
- **RUN, wait counter < `DUT_LAT`:** increment the counter; hold operands.
- **RUN, wait counter == `DUT_LAT` (check edge):** compare `dut_gt` with the expected value.
  - Mismatch: capture `fail_a`/`fail_b` from the current operands, set `pass`=0, go to DONE.
  - Match and `a_out`==0: set `pass`=1, go to DONE.
  - Match otherwise: `a_out` decrements by 1 and `b_out` increments by 1, both modulo 2^WIDTH. Clear the counter and stay in RUN.
- **Expected value:** unsigned `a_out > b_out` by default; see Configuration.
- **Operand sum:** `a_out + b_out` always equals all ones, so A==B never occurs.
- **Vector count:** a full sweep checks 2^WIDTH vectors; 65536 for `WIDTH`=16.
- **`start` while RUN:** ignored; the sweep is not restarted.
- **Reset mid-sweep:** immediate return to reset values; no partial result is reported.
- **Status outputs:**
  - `busy` = (state == RUN).
  - `done` = (state == DONE).

## Timing
- **Start to first drive:** `start` sampled at edge N; first operands are visible after edge N, and `busy` rises after edge N.
- **Vector rate:** one vector every `DUT_LAT`+1 cycles.
- **Sampling point:** `dut_gt` is sampled `DUT_LAT` edges after the operands change. With `DUT_LAT`=0 the comparator is combinational and is sampled in the same cycle the operands are presented.
- **Full passing sweep:** `busy` is high for 2^WIDTH × (`DUT_LAT`+1) cycles. `done` rises on the edge of the final check.
- **Failing sweep:** `done` rises on the edge of the first mismatching check.
- **Result hold:** `done`, `pass` and `fail_*` hold until the next accepted `start` or reset.
- **Output registering:** all outputs are registered; there is no combinational path from `dut_gt` to any output.

## Configuration
- **Macro:** `CMP_BIST_SIGNED_EN`.
- **Defined:** expected = `$signed(a_out) > $signed(b_out)`, for checking the comparator's signed (SLT/branch) mode.
- **Undefined:** expected = unsigned `a_out > b_out`.
- **Unaffected:** sweep order, state machine and timing are identical in both builds.

## Structure
- **Shared package `cmp_bist_pkg`:**
  - State encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - Operand reset constants (`A_INIT` = all ones, `B_INIT` = 0).
  - Wait-counter width (2 bits).
- **Sub-module `cmp_bist_model`:** combinational expected-value model taking A and B and producing `exp_gt`. It holds the `CMP_BIST_SIGNED_EN` selection, so the sequencer itself is mode-agnostic.

## Test plan
- **Reset mid-run:** with `DUT_LAT`=0, start, then assert `rst` at cycle 100 → all outputs return to reset values; `a_out`=16'hFFFF, `b_out`=0, `busy`=0.
- **Correct unsigned comparator, `DUT_LAT`=0:** pulse `start` → first vector is A=16'hFFFF, B=16'h0000, expecting 1. Sweep finishes after 65536 cycles with `done`=1, `pass`=1, `fail_a`=`fail_b`=0.
- **Correct comparator registered once, `DUT_LAT`=1:** pulse `start` → `done` rises after 131072 cycles with `pass`=1.
- **Stuck-high fault:** `dut_gt` forced to 1 when A=16'h7FFF, B=16'h8000 → `done`=1, `pass`=0, `fail_a`=16'h7FFF, `fail_b`=16'h8000.
- **Signed build:** with `CMP_BIST_SIGNED_EN` defined and an unsigned-only comparator, start → fails on the first vector with `fail_a`=16'hFFFF, `fail_b`=16'h0000.
- **Start while busy:** pulse `start` at cycle 10 of a sweep → ignored; the operand sequence continues with no restart, and completion timing is unchanged.

Source files
------------

// File: rtl/cmp_bist_pkg.sv
// Shared definitions for the cmp_bist comparator self-test sequencer.
package cmp_bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned CNT_W = 2;

    // Operand seeds; both are uniform fills, so bit 0 replicates them to any width.
    localparam logic [15:0] A_INIT = '1;
    localparam logic [15:0] B_INIT = '0;

endpackage

// File: rtl/cmp_bist_if.sv
// Handshake and operand bundle between cmp_bist and its comparator/controller.
interface cmp_bist_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;
    logic             dut_gt;
    logic             busy;
    logic             done;
    logic             pass;
    logic [WIDTH-1:0] fail_a;
    logic [WIDTH-1:0] fail_b;

    modport master (
        input  start, dut_gt,
        output a_out, b_out, busy, done, pass, fail_a, fail_b
    );

    modport slave (
        output start, dut_gt,
        input  a_out, b_out, busy, done, pass, fail_a, fail_b
    );
endinterface

// File: rtl/cmp_bist_model.sv
// Expected greater-than model; CMP_BIST_SIGNED_EN selects signed compare.
module cmp_bist_model #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             exp_gt
);

    always_comb begin
`ifdef CMP_BIST_SIGNED_EN
        exp_gt = $signed(a) > $signed(b);
`else
        exp_gt = a > b;
`endif
    end

endmodule

// File: rtl/cmp_bist.sv
// Comparator BIST sequencer: sweeps A down from all ones and B up from zero.
// Build option CMP_BIST_SIGNED_EN switches the expected model to signed compare.
module cmp_bist
    import cmp_bist_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned DUT_LAT = 0
) (
    input  logic          clk,
    input  logic          rst,
    cmp_bist_if.master    bus
);

    localparam logic [CNT_W-1:0] LAT   = CNT_W'(DUT_LAT);
    localparam logic [WIDTH-1:0] A_RST = {WIDTH{A_INIT[0]}};
    localparam logic [WIDTH-1:0] B_RST = {WIDTH{B_INIT[0]}};

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   fa_q, fa_d;
    logic [WIDTH-1:0]   fb_q, fb_d;
    logic               pass_q, pass_d;
    logic               exp_gt;

    cmp_bist_model #(.WIDTH(WIDTH)) u_model (
        .a      (a_q),
        .b      (b_q),
        .exp_gt (exp_gt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= A_RST;
            b_q     <= B_RST;
            fa_q    <= '0;
            fb_q    <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            fa_q    <= fa_d;
            fb_q    <= fb_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        fa_d    = fa_q;
        fb_d    = fb_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    a_d     = A_RST;
                    b_d     = B_RST;
                    fa_d    = '0;
                    fb_d    = '0;
                    pass_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q != LAT) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (bus.dut_gt != exp_gt) begin
                    fa_d    = a_q;
                    fb_d    = b_q;
                    pass_d  = 1'b0;
                    state_d = DONE;
                end else if (a_q == '0) begin
                    pass_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    // A+B stays all ones, so A==B is never presented.
                    a_d   = a_q - WIDTH'(1);
                    b_d   = b_q + WIDTH'(1);
                    cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.a_out  = a_q;
    assign bus.b_out  = b_q;
    assign bus.busy   = (state_q == RUN);
    assign bus.done   = (state_q == DONE);
    assign bus.pass   = pass_q;
    assign bus.fail_a = fa_q;
    assign bus.fail_b = fb_q;

endmodule

// File: tb/tb_cmp_bist.sv
// Directed bench for cmp_bist: 16-bit/LAT0, 8-bit/LAT0 and 8-bit/LAT1 instances.
module tb_cmp_bist;

    localparam int LIMIT = 40000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cmp_bist_if #(.WIDTH(16)) if16 ();
    cmp_bist_if #(.WIDTH(8))  if8z ();
    cmp_bist_if #(.WIDTH(8))  if8r ();

    // mode 0: correct comparator; 1: wrong answer at the 0111../1000.. vector;
    // 2: unsigned-only comparator (differs from correct only in the signed build)
    int mode16 = 0;
    int mode8z = 0;
    int mode8r = 0;

    int n_cmp  = 0;
    int n_fail = 0;

    function automatic logic gt16(input logic [15:0] a, input logic [15:0] b, input int mode);
        logic g;
`ifdef CMP_BIST_SIGNED_EN
        g = (mode == 2) ? (a > b) : ($signed(a) > $signed(b));
`else
        g = a > b;
`endif
        if (mode == 1 && a == 16'h7FFF && b == 16'h8000) g = ~g;
        return g;
    endfunction

    function automatic logic gt8(input logic [7:0] a, input logic [7:0] b, input int mode);
        logic g;
`ifdef CMP_BIST_SIGNED_EN
        g = (mode == 2) ? (a > b) : ($signed(a) > $signed(b));
`else
        g = a > b;
`endif
        if (mode == 1 && a == 8'h7F && b == 8'h80) g = ~g;
        return g;
    endfunction

    logic gt8r_q;
    assign if16.dut_gt = gt16(if16.a_out, if16.b_out, mode16);
    assign if8z.dut_gt = gt8(if8z.a_out, if8z.b_out, mode8z);
    always_ff @(posedge clk) gt8r_q <= gt8(if8r.a_out, if8r.b_out, mode8r);
    assign if8r.dut_gt = gt8r_q;

    cmp_bist #(.WIDTH(16), .DUT_LAT(0)) u16  (.clk(clk), .rst(rst), .bus(if16));
    cmp_bist #(.WIDTH(8),  .DUT_LAT(0)) u8z  (.clk(clk), .rst(rst), .bus(if8z));
    cmp_bist #(.WIDTH(8),  .DUT_LAT(1)) u8r  (.clk(clk), .rst(rst), .bus(if8r));

    typedef struct {
        int          dut;
        int          mode;
        logic        exp_pass;
        logic [15:0] exp_fa;
        logic [15:0] exp_fb;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
        int          exp_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive_start(input int d, input logic v);
        case (d)
            0:       if16.start = v;
            1:       if8z.start = v;
            default: if8r.start = v;
        endcase
    endtask

    task automatic set_mode(input int d, input int m);
        case (d)
            0:       mode16 = m;
            1:       mode8z = m;
            default: mode8r = m;
        endcase
    endtask

    function automatic logic busy_of(input int d);
        case (d)
            0:       return if16.busy;
            1:       return if8z.busy;
            default: return if8r.busy;
        endcase
    endfunction

    task automatic get_res(input int d, output logic dn, output logic ps,
                           output logic [15:0] fa, output logic [15:0] fb,
                           output logic [15:0] a, output logic [15:0] b);
        case (d)
            0: begin
                dn = if16.done; ps = if16.pass; fa = if16.fail_a; fb = if16.fail_b;
                a = if16.a_out; b = if16.b_out;
            end
            1: begin
                dn = if8z.done; ps = if8z.pass; fa = {8'h00, if8z.fail_a}; fb = {8'h00, if8z.fail_b};
                a = {8'h00, if8z.a_out}; b = {8'h00, if8z.b_out};
            end
            default: begin
                dn = if8r.done; ps = if8r.pass; fa = {8'h00, if8r.fail_a}; fb = {8'h00, if8r.fail_b};
                a = {8'h00, if8r.a_out}; b = {8'h00, if8r.b_out};
            end
        endcase
    endtask

    // Counts busy cycles from the start edge until busy falls, bounded by LIMIT.
    task automatic run_sweep(input int d, output logic dn0, output int cyc);
        logic ps;
        logic [15:0] fa, fb, a, b;
        @(negedge clk);
        drive_start(d, 1'b1);
        @(negedge clk);
        drive_start(d, 1'b0);
        get_res(d, dn0, ps, fa, fb, a, b);
        cyc = 0;
        while (busy_of(d) && cyc < LIMIT) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    initial begin
        logic        dn, ps, dn0;
        logic [15:0] fa, fb, a, b;
        int          cyc;

        if16.start = 1'b0;
        if8z.start = 1'b0;
        if8r.start = 1'b0;

        // Reset values
        #2 rst = 1'b1;
        #1;
        chk("rst_a",    if16.a_out,  16'hFFFF);
        chk("rst_b",    if16.b_out,  16'h0000);
        chk("rst_busy", if16.busy,   1'b0);
        chk("rst_done", if16.done,   1'b0);
        chk("rst_pass", if16.pass,   1'b0);
        chk("rst_fa",   if16.fail_a, 16'h0000);
        chk("rst_fb",   if16.fail_b, 16'h0000);
        chk("rst_a8",   if8r.a_out,  8'hFF);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_busy", if16.busy, 1'b0);

        // First vector and reset mid-run
        if16.start = 1'b1;
        @(negedge clk);
        if16.start = 1'b0;
        chk("v0_busy", if16.busy,  1'b1);
        chk("v0_a",    if16.a_out, 16'hFFFF);
        chk("v0_b",    if16.b_out, 16'h0000);
        repeat (100) @(negedge clk);
        chk("c100_a",    if16.a_out, 16'hFF9B);
        chk("c100_b",    if16.b_out, 16'h0064);
        chk("c100_busy", if16.busy,  1'b1);
        #2 rst = 1'b1;
        #1;
        chk("mrst_a",    if16.a_out, 16'hFFFF);
        chk("mrst_b",    if16.b_out, 16'h0000);
        chk("mrst_busy", if16.busy,  1'b0);
        chk("mrst_done", if16.done,  1'b0);
        chk("mrst_pass", if16.pass,  1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_idle", if16.busy, 1'b0);

        // Start while busy on the 8-bit LAT0 instance
        if8z.start = 1'b1;
        @(negedge clk);
        if8z.start = 1'b0;
        repeat (9) @(negedge clk);
        if8z.start = 1'b1;
        @(negedge clk);
        if8z.start = 1'b0;
        chk("swb_a", if8z.a_out, 8'hF5);
        chk("swb_b", if8z.b_out, 8'h0A);
        cyc = 10;
        while (if8z.busy && cyc < LIMIT) begin
            cyc++;
            @(negedge clk);
        end
        chk("swb_cycles", cyc, 256);
        chk("swb_done",   if8z.done, 1'b1);
        chk("swb_pass",   if8z.pass, 1'b1);

        // Whole-sweep table
        vecs.push_back('{2, 1, 1'b0, 16'h007F, 16'h0080, 16'h007F, 16'h0080, 258});
        vecs.push_back('{2, 0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h00FF, 512});
        vecs.push_back('{1, 1, 1'b0, 16'h007F, 16'h0080, 16'h007F, 16'h0080, 129});
        vecs.push_back('{1, 0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h00FF, 256});
        vecs.push_back('{0, 1, 1'b0, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 32769});
`ifdef CMP_BIST_SIGNED_EN
        vecs.push_back('{0, 2, 1'b0, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 1});
        vecs.push_back('{2, 2, 1'b0, 16'h00FF, 16'h0000, 16'h00FF, 16'h0000, 2});
`endif
        foreach (vecs[i]) begin
            set_mode(vecs[i].dut, vecs[i].mode);
            run_sweep(vecs[i].dut, dn0, cyc);
            get_res(vecs[i].dut, dn, ps, fa, fb, a, b);
            chk($sformatf("t%0d_done_clr", i), dn0, 1'b0);
            chk($sformatf("t%0d_cycles", i),   cyc, vecs[i].exp_busy);
            chk($sformatf("t%0d_done", i),     dn,  1'b1);
            chk($sformatf("t%0d_pass", i),     ps,  vecs[i].exp_pass);
            chk($sformatf("t%0d_fail_a", i),   fa,  vecs[i].exp_fa);
            chk($sformatf("t%0d_fail_b", i),   fb,  vecs[i].exp_fb);
            chk($sformatf("t%0d_a", i),        a,   vecs[i].exp_a);
            chk($sformatf("t%0d_b", i),        b,   vecs[i].exp_b);
            repeat (3) @(negedge clk);
            get_res(vecs[i].dut, dn, ps, fa, fb, a, b);
            chk($sformatf("t%0d_hold_done", i), dn, 1'b1);
            chk($sformatf("t%0d_hold_fa", i),   fa, vecs[i].exp_fa);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
